// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a 2-entry output skid buffer.
//
// The immediate is decoded combinationally from the incoming instruction and
// captured into the buffer when a beat is accepted. The buffer head drives the
// outputs, so nothing on the input side reaches out_valid/out_imm within a cycle.
//
// Parameters:
//   XLEN  - immediate width, 32 or 64
//   TAG_W - sideband tag width
//
// Ports:
//   CLK, RESET              - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     - input handshake
//   in_inst, in_imm_sel     - instruction word; [2:0] format, [3] zero-extend modifier
//   in_tag                  - sideband carried with the beat
//   flush                   - drop every buffered beat and the beat offered this cycle
//   out_valid / out_ready   - output handshake
//   out_imm, out_tag        - head-of-buffer immediate and tag (zero when not valid)
//   out_illegal             - head beat used a reserved or unsupported select code
//
// Build option:
//   IMM_GEN_CSR_EN - when defined, select code 3'b110 decodes the CSR uimm
//                    (zero-extended inst[19:15]); otherwise it is reserved.

module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [3:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;

  localparam logic [2:0] FMT_U     = 3'b000;
  localparam logic [2:0] FMT_J     = 3'b001;
  localparam logic [2:0] FMT_I     = 3'b010;
  localparam logic [2:0] FMT_B     = 3'b011;
  localparam logic [2:0] FMT_S     = 3'b100;
  localparam logic [2:0] FMT_SHAMT = 3'b101;
  localparam logic [2:0] FMT_CSR   = 3'b110;
  localparam logic [2:0] FMT_RSVD  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0]       fmt;
  logic             uns;
  logic [XLEN-1:0]  imm_new;
  logic             ill_new;
  logic             push;
  logic             pop;
  logic             tail;
  logic             unused_inst_bits;

  assign fmt = in_imm_sel[2:0];
  assign uns = in_imm_sel[3];

  // Opcode bits never contribute to any immediate.
  assign unused_inst_bits = ^in_inst[6:0];

  // Immediate decode; size casts of signed operands perform the sign extension.
  always_comb begin
    imm_new = '0;
    ill_new = 1'b0;
    unique case (fmt)
      FMT_U: begin
        imm_new = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      FMT_J: begin
        if (uns) begin
          imm_new = XLEN'({in_inst[31:12], 1'b0});
        end else begin
          imm_new = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21], 1'b0}));
        end
      end
      FMT_I: begin
        if (uns) begin
          imm_new = XLEN'(in_inst[31:20]);
        end else begin
          imm_new = XLEN'($signed(in_inst[31:20]));
        end
      end
      FMT_B: begin
        imm_new = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
      end
      FMT_S: begin
        if (uns) begin
          imm_new = XLEN'({in_inst[31:25], in_inst[11:7]});
        end else begin
          imm_new = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        end
      end
      FMT_SHAMT: begin
        // RV64 shift amounts carry one more bit than RV32.
        if (XLEN == 64) begin
          imm_new = XLEN'(in_inst[25:20]);
        end else begin
          imm_new = XLEN'(in_inst[24:20]);
        end
      end
      FMT_CSR: begin
`ifdef IMM_GEN_CSR_EN
        imm_new = XLEN'(in_inst[19:15]);
`else
        ill_new = 1'b1;
`endif
      end
      FMT_RSVD: begin
        ill_new = 1'b1;
      end
      default: begin
        ill_new = 1'b1;
      end
    endcase
  end

  // Ready and valid come from the registered occupancy only.
  assign in_ready  = !RESET && (count_q < CNT_W'(DEPTH));
  assign out_valid = !RESET && (count_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign tail = head_q ^ count_q[0];

  // Buffer next state: flush empties it after letting a same-cycle pop complete.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    if (pop) begin
      head_d = ~head_q;
    end
    if (flush) begin
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail] = '{imm: imm_new, tag: in_tag, illegal: ill_new};
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs are forced to zero whenever no beat is presented.
  assign out_imm     = out_valid ? mem_q[head_q].imm     : '0;
  assign out_tag     = out_valid ? mem_q[head_q].tag     : '0;
  assign out_illegal = out_valid ? mem_q[head_q].illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives an XLEN=32 and an XLEN=64 instance from the
// same stimulus, checks both every cycle against a queue-based model, and pins
// the model with hand-computed directed expectations.

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [3:0]  in_imm_sel = '0;
  logic [31:0] in_tag = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [31:0] tag32, tag64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .flush(flush),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32),
    .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .CLK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .flush(flush),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64),
    .out_illegal(ill64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q[$];

  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    longint v;
    v = longint'({32'b0, w}) >> lo;
    return v & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic longint sext(input longint v, input int n);
    if ((v & (longint'(1) << (n - 1))) != 0) return v - (longint'(1) << n);
    return v;
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic [3:0] sel,
                                 input logic [31:0] tag);
    exp_t   e;
    longint v, v32, raw;
    logic   u;
    u = sel[3];
    e.ill = 1'b0;
    v = 0;
    case (sel[2:0])
      3'd0: v = sext(fld(w, 31, 12) << 12, 32);
      3'd1: begin
        raw = (fld(w, 31, 31) << 20) | (fld(w, 19, 12) << 12) |
              (fld(w, 20, 20) << 11) | (fld(w, 30, 21) << 1);
        v = u ? (fld(w, 31, 12) << 1) : sext(raw, 21);
      end
      3'd2: v = u ? fld(w, 31, 20) : sext(fld(w, 31, 20), 12);
      3'd3: begin
        raw = (fld(w, 31, 31) << 12) | (fld(w, 7, 7) << 11) |
              (fld(w, 30, 25) << 5) | (fld(w, 11, 8) << 1);
        v = sext(raw, 13);
      end
      3'd4: begin
        raw = (fld(w, 31, 25) << 5) | fld(w, 11, 7);
        v = u ? raw : sext(raw, 12);
      end
      3'd5: v = fld(w, 25, 20);
`ifdef IMM_GEN_CSR_EN
      3'd6: v = fld(w, 19, 15);
`else
      3'd6: e.ill = 1'b1;
`endif
      default: e.ill = 1'b1;
    endcase
    v32 = (sel[2:0] == 3'd5) ? fld(w, 24, 20) : v;
    e.i64 = 64'(v);
    e.i32 = 32'(v32);
    e.tag = tag;
    return e;
  endfunction

  // Model state advances on the same edge the DUT samples.
  always @(posedge clk) begin
    bit push, pop;
    if (rst) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (push) q.push_back(model(in_inst, in_imm_sel, in_tag));
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit   ev;
    exp_t h;
    ev = !rst && (q.size() > 0);
    chk("in_ready32", 64'(rdy32), 64'(!rst && (q.size() < 2)));
    chk("in_ready64", 64'(rdy64), 64'(!rst && (q.size() < 2)));
    chk("out_valid32", 64'(ov32), 64'(ev));
    chk("out_valid64", 64'(ov64), 64'(ev));
    if (ev) begin
      h = q[0];
      chk("imm32", 64'(imm32), 64'(h.i32));
      chk("imm64", imm64, h.i64);
      chk("tag32", 64'(tag32), 64'(h.tag));
      chk("tag64", 64'(tag64), 64'(h.tag));
      chk("ill32", 64'(ill32), 64'(h.ill));
      chk("ill64", 64'(ill64), 64'(h.ill));
    end else begin
      chk("idle_zero32", {31'b0, ill32, imm32}, 64'd0);
      chk("idle_zero64", imm64 | 64'(ill64) | 64'(tag64) | 64'(tag32), 64'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input string name, input logic [31:0] w, input logic [3:0] sel,
                      input logic [31:0] tag, input logic [31:0] e32,
                      input logic [63:0] e64, input logic eill);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    in_inst = w; in_imm_sel = sel; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 64'(ov32 & ov64), 64'd1);
    chk({name, "_imm32"}, 64'(imm32), 64'(e32));
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_ill"}, {62'b0, ill64, ill32}, {62'b0, eill, eill});
    chk({name, "_tag"}, 64'(tag32), 64'(tag));
  endtask

  task automatic cycle;
    @(posedge clk); #1;
  endtask

  int tags_seen[$];

  initial begin
    // Reset held three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {62'b0, rdy64, rdy32}, 64'd0);
    chk("rst_out_valid", {62'b0, ov64, ov32}, 64'd0);
    chk("rst_imm", 64'(imm32) | imm64, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {62'b0, rdy64, rdy32}, 64'd3);

    send("I_signed",   32'hFFF00093, 4'b0010, 32'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send("I_unsigned", 32'hFFF00093, 4'b1010, 32'h12, 32'h00000FFF, 64'h0000000000000FFF, 1'b0);
    send("B_neg",      32'hFE000EE3, 4'b0011, 32'h13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send("B_modifier", 32'hFE000EE3, 4'b1011, 32'h14, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send("SHAMT",      32'h03F01013, 4'b0101, 32'h15, 32'h0000001F, 64'h000000000000003F, 1'b0);
    send("U_pos",      32'h12345037, 4'b0000, 32'h16, 32'h12345000, 64'h0000000012345000, 1'b0);
    send("U_neg",      32'h80000037, 4'b1000, 32'h17, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    send("S_signed",   32'hFE000E23, 4'b0100, 32'h18, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send("S_unsigned", 32'hFE000E23, 4'b1100, 32'h19, 32'h00000FFC, 64'h0000000000000FFC, 1'b0);
    send("J_signed",   32'h800000EF, 4'b0001, 32'h1A, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
    send("J_unsigned", 32'h800000EF, 4'b1001, 32'h1B, 32'h00100000, 64'h0000000000100000, 1'b0);
    send("reserved",   32'hFFFFFFFF, 4'b0111, 32'h1C, 32'h0, 64'h0, 1'b1);
`ifdef IMM_GEN_CSR_EN
    send("csr",        32'h000FD073, 4'b0110, 32'h1D, 32'h1F, 64'h1F, 1'b0);
`else
    send("csr",        32'h000FD073, 4'b0110, 32'h1D, 32'h0, 64'h0, 1'b1);
`endif

    // Backpressure: three beats offered while the consumer stalls.
    cycle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_imm_sel = 4'b0010; in_tag = 32'd1;
    cycle();
    in_tag = 32'd2;
    cycle();
    in_tag = 32'd3;
    @(negedge clk);
    chk("bp_full_ready", 64'(rdy32), 64'd0);
    chk("bp_head_tag", 64'(tag32), 64'd1);
    cycle(); cycle();
    @(negedge clk);
    chk("bp_hold_tag", 64'(tag32), 64'd1);
    chk("bp_hold_imm", 64'(imm32), 64'hFFFFFFFF);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit acc;
      @(negedge clk);
      if (ov32 && out_ready) tags_seen.push_back(int'(tag32));
      acc = in_valid && rdy32;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 64'(tags_seen.size()), 64'd3);
    if (tags_seen.size() == 3) begin
      chk("bp_order0", 64'(tags_seen[0]), 64'd1);
      chk("bp_order1", 64'(tags_seen[1]), 64'd2);
      chk("bp_order2", 64'(tags_seen[2]), 64'd3);
    end
    in_valid = 1'b0;

    // Flush with a full buffer and a beat offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'h10;
    cycle();
    in_tag = 32'h11;
    cycle();
    flush = 1'b1; in_tag = 32'h12;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", 64'(ov32 | ov64), 64'd0);
    chk("flush_full_ready", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      @(negedge clk);
      chk("flush_full_drained", 64'(ov32 | ov64), 64'd0);
    end

    // Flush wins over a push accepted in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'h20;
    cycle();
    flush = 1'b1; in_tag = 32'h21;
    @(negedge clk);
    chk("flush_push_ready", 64'(rdy32), 64'd1);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_push_valid", 64'(ov32 | ov64), 64'd0);
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      @(negedge clk);
      chk("flush_push_dropped", 64'(ov32 | ov64), 64'd0);
    end

    // Reset mid-transfer drops contents.
    cycle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 32'h30;
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_pre_valid", 64'(ov32), 64'd1);
    cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {62'b0, rdy64, rdy32}, 64'd0);
    chk("mid_rst_valid", {62'b0, ov64, ov32}, 64'd0);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_after_valid", 64'(ov32), 64'd0);
    chk("mid_rst_after_ready", 64'(rdy32), 64'd1);
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
